des_operand_loader: RTL and testbench

- Input-side counterpart to the seven-segment display path: the display shows 64-bit DES operands, and this block lets the user enter them.
- The user keys in a 64-bit key or plaintext one byte at a time from the slide switches, using debounced push buttons.
- When 8 bytes are entered, the assembled word is committed to the key or plaintext register that feeds the DES core and the display mux.
- Sits in the top-level board wrapper, between the raw switch/button pins and the DES instance.

---
 rtl/des_io_pkg.sv | 19 +
 rtl/button_debouncer.sv | 48 ++++
 rtl/des_operand_loader.sv | 111 +++++++++++
 tb/tb_des_operand_loader.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/des_io_pkg.sv
// Shared types and constants for the DES operand entry path.
// Imported by the debouncer and by the operand loader top.
package des_io_pkg;

   localparam int BYTES_PER_WORD = 8;

   localparam logic [63:0] KEY_INIT_DEFAULT = 64'h433E4529462A4A62;
   localparam logic [63:0] PT_INIT_DEFAULT  = 64'h2579DB866C0F528C;

   // Byte [7] is the MSB byte, which is the first one keyed in.
   typedef logic [BYTES_PER_WORD-1:0][7:0] word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ENTRY  = 2'd1,
      COMMIT = 2'd2
   } state_e;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes a raw push button, debounces it, and emits a one-cycle pulse
// on each accepted rising edge of the debounced level.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1250000
) (
   input  logic sysclk_125mhz,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic rise_pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1_q, sync2_q;
   logic [CW-1:0] cnt_q;
   logic          level_q, level_prev_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would collapse the 2-FF chain.
   always_ff @(posedge sysclk_125mhz or negedge rst) begin
      if (!rst) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         cnt_q        <= '0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
      end else begin
         sync1_q      <= btn_raw;
         sync2_q      <= sync1_q;
         level_prev_q <= level_q;
         if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
               level_q <= sync2_q;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign level      = level_q;
   assign rise_pulse = level_q & ~level_prev_q;

endmodule

// File: rtl/des_operand_loader.sv
// Byte-serial entry of 64-bit DES key/plaintext from switches and buttons;
// a completed word is committed to the selected operand register.
module des_operand_loader
   import des_io_pkg::*;
#(
   parameter int          DEBOUNCE_CYCLES = 1250000,
   parameter logic [63:0] KEY_INIT        = KEY_INIT_DEFAULT,
   parameter logic [63:0] PT_INIT         = PT_INIT_DEFAULT
) (
   input  logic        sysclk_125mhz,
   input  logic        rst,
   input  logic [7:0]  sw_byte,
   input  logic        sel_target,
   input  logic        btn_load,
   input  logic        btn_clear,
   output logic [63:0] key_out,
   output logic [63:0] plaintext_out,
   output logic [2:0]  byte_idx,
   output logic        entry_active,
   output logic        commit_pulse
);

   logic load_p, clear_p;
   logic load_level_unused, clear_level_unused;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
      .sysclk_125mhz (sysclk_125mhz),
      .rst           (rst),
      .btn_raw       (btn_load),
      .level         (load_level_unused),
      .rise_pulse    (load_p)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
      .sysclk_125mhz (sysclk_125mhz),
      .rst           (rst),
      .btn_raw       (btn_clear),
      .level         (clear_level_unused),
      .rise_pulse    (clear_p)
   );

   state_e      state_q, state_d;
   word_t       staging_q, staging_d;
   logic [2:0]  idx_q, idx_d;
   logic [63:0] key_q, key_d;
   logic [63:0] pt_q, pt_d;
   logic        commit_q, commit_d;

   // NOTE: every next-state signal gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      staging_d = staging_q;
      idx_d     = idx_q;
      key_d     = key_q;
      pt_d      = pt_q;
      commit_d  = 1'b0;
      case (state_q)
         IDLE, ENTRY: begin
            // Clear has priority; a simultaneous load byte is dropped.
            if (clear_p) begin
               staging_d = '0;
               idx_d     = '0;
               state_d   = IDLE;
            end else if (load_p) begin
               staging_d[3'(BYTES_PER_WORD - 1) - idx_q] = sw_byte;
               if (idx_q == 3'(BYTES_PER_WORD - 1)) begin
                  state_d = COMMIT;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = ENTRY;
               end
            end
         end
         COMMIT: begin
            if (sel_target) pt_d  = staging_q;
            else            key_d = staging_q;
            commit_d  = 1'b1;
            staging_d = '0;
            idx_d     = '0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sysclk_125mhz or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         staging_q <= '0;
         idx_q     <= '0;
         key_q     <= KEY_INIT;
         pt_q      <= PT_INIT;
         commit_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         staging_q <= staging_d;
         idx_q     <= idx_d;
         key_q     <= key_d;
         pt_q      <= pt_d;
         commit_q  <= commit_d;
      end
   end

   assign key_out       = key_q;
   assign plaintext_out = pt_q;
   assign byte_idx      = idx_q;
   assign entry_active  = (state_q == ENTRY);
   assign commit_pulse  = commit_q;

endmodule

// File: tb/tb_des_operand_loader.sv
// Directed self-checking bench for des_operand_loader with a short debounce.
module tb_des_operand_loader;

   localparam int          DB      = 4;
   localparam logic [63:0] KEY_RST = 64'h433E4529462A4A62;
   localparam logic [63:0] PT_RST  = 64'h2579DB866C0F528C;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  sw_byte = 8'h00;
   logic        sel_target = 1'b0;
   logic        btn_load = 1'b0;
   logic        btn_clear = 1'b0;
   logic [63:0] key_out, plaintext_out;
   logic [2:0]  byte_idx;
   logic        entry_active, commit_pulse;

   int n_checks = 0;
   int n_errors = 0;
   int commit_cnt = 0;

   always #4 clk = ~clk;

   des_operand_loader #(.DEBOUNCE_CYCLES(DB)) dut (
      .sysclk_125mhz (clk),
      .rst           (rst),
      .sw_byte       (sw_byte),
      .sel_target    (sel_target),
      .btn_load      (btn_load),
      .btn_clear     (btn_clear),
      .key_out       (key_out),
      .plaintext_out (plaintext_out),
      .byte_idx      (byte_idx),
      .entry_active  (entry_active),
      .commit_pulse  (commit_pulse)
   );

   always @(negedge clk) if (rst && commit_pulse) commit_cnt++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Holds the button(s) long enough for the debounced pulse, then releases.
   task automatic press(input logic ld, input logic clr);
      @(negedge clk);
      btn_load  = ld;
      btn_clear = clr;
      repeat (12) @(negedge clk);
      btn_load  = 1'b0;
      btn_clear = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic load_byte(input logic [7:0] b);
      sw_byte = b;
      press(1'b1, 1'b0);
   endtask

   initial begin
      logic [23:0] glitch;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_key", key_out, KEY_RST);
      check("rst_pt", plaintext_out, PT_RST);
      check("rst_idx", 64'(byte_idx), 64'd0);
      check("rst_entry", 64'(entry_active), 64'd0);
      repeat (20) @(negedge clk);
      check("idle_no_commit", 64'(commit_cnt), 64'd0);

      // Key 0102030405060708, MSB byte first.
      sel_target = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         load_byte(8'(i));
         check($sformatf("key_idx_%0d", i), 64'(byte_idx), 64'(i % 8));
      end
      check("key_commits", 64'(commit_cnt), 64'd1);
      check("key_value", key_out, 64'h0102030405060708);
      check("key_pt_kept", plaintext_out, PT_RST);
      check("key_entry_off", 64'(entry_active), 64'd0);

      // Glitchy load: runs of at most 2 cycles never satisfy the debounce.
      sw_byte = 8'h11;
      glitch  = 24'b0110_1001_1011_0100_1101_0010;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         btn_load = glitch[i];
      end
      check("glitch_idx_before", 64'(byte_idx), 64'd0);
      btn_load = 1'b1;
      repeat (12) @(negedge clk);
      btn_load = 1'b0;
      repeat (12) @(negedge clk);
      check("glitch_idx", 64'(byte_idx), 64'd1);
      check("glitch_entry", 64'(entry_active), 64'd1);

      load_byte(8'h22);
      load_byte(8'h33);
      check("pre_clear_idx", 64'(byte_idx), 64'd3);
      press(1'b0, 1'b1);
      check("clear_idx", 64'(byte_idx), 64'd0);
      check("clear_entry", 64'(entry_active), 64'd0);
      check("clear_key_kept", key_out, 64'h0102030405060708);
      check("clear_pt_kept", plaintext_out, PT_RST);
      check("clear_no_commit", 64'(commit_cnt), 64'd1);

      // Plaintext all AA.
      sel_target = 1'b1;
      for (int i = 0; i < 8; i++) load_byte(8'hAA);
      check("pt_value", plaintext_out, 64'hAAAAAAAAAAAAAAAA);
      check("pt_key_kept", key_out, 64'h0102030405060708);
      check("pt_commits", 64'(commit_cnt), 64'd2);

      // Load and clear pulses land in the same cycle at byte_idx 5.
      for (int i = 0; i < 5; i++) load_byte(8'h55);
      check("both_pre_idx", 64'(byte_idx), 64'd5);
      sw_byte = 8'h99;
      press(1'b1, 1'b1);
      check("both_idx", 64'(byte_idx), 64'd0);
      check("both_entry", 64'(entry_active), 64'd0);
      check("both_no_commit", 64'(commit_cnt), 64'd2);

      // Fresh word after the drop must start at the MSB byte.
      sel_target = 1'b0;
      for (int i = 8; i >= 1; i--) load_byte(8'(9 - i));
      check("rekey_value", key_out, 64'h0102030405060708);
      check("rekey_pt_kept", plaintext_out, 64'hAAAAAAAAAAAAAAAA);

      // Asynchronous reset mid-entry.
      for (int i = 0; i < 6; i++) load_byte(8'hC3);
      check("mid_idx", 64'(byte_idx), 64'd6);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("arst_key", key_out, KEY_RST);
      check("arst_pt", plaintext_out, PT_RST);
      check("arst_idx", 64'(byte_idx), 64'd0);
      check("arst_entry", 64'(entry_active), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      load_byte(8'h7E);
      check("post_rst_idx", 64'(byte_idx), 64'd1);
      check("post_rst_key", key_out, KEY_RST);
      check("total_commits", 64'(commit_cnt), 64'd3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
